sim_lcd_sequencer: RTL and testbench

Top-level sequencer between the SIM reader datapath and the character-LCD line writer. It enables a SIM read, waits for completion or timeout, then pushes the two stored phonebook contacts to a two-line LCD, one contact at a time. Each contact is a name line and a number line, selected through the reader's 2-bit page select. A debounced pushbutton or an idle dwell timer advances between contacts.

---
 rtl/sim_lcd_sequencer.sv | 177 +++++++++++++++++
 tb/tb_sim_lcd_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_lcd_sequencer.sv
// sim_lcd_sequencer: enables a SIM read, waits for Hecho or timeout, then shows
// the two stored phonebook contacts on a two-line LCD, one at a time. A
// debounced pushbutton or an idle dwell timer switches between contacts.
//
// LCD handshake: LCD_Req is a level request. While it is high, DatoW and
// LCD_Linea hold the line to write and stay stable until the edge that samples
// LCD_Ack=1. That edge consumes the current line. If another line follows
// (L0 -> L1), LCD_Req stays high and DatoW/LCD_Linea change at that same edge.
// LCD_Ack is ignored whenever LCD_Req is low.
module sim_lcd_sequencer #(
    parameter int TIMEOUT_CYCLES  = 50_000_000,
    parameter int DWELL_CYCLES    = 150_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Boton,
    output logic       Habilitar,
    input  logic       Hecho,
    output logic [1:0] DatoW,
    output logic       LCD_Req,
    output logic       LCD_Linea,
    input  logic       LCD_Ack,
    output logic       Error,
    output logic [2:0] Estado
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEER  = 3'd1;
    localparam logic [2:0] S_L0    = 3'd2;
    localparam logic [2:0] S_L1    = 3'd3;
    localparam logic [2:0] S_PAUSA = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam int TO_W = (TIMEOUT_CYCLES  > 1) ? $clog2(TIMEOUT_CYCLES)  : 1;
    localparam int DW_W = (DWELL_CYCLES    > 1) ? $clog2(DWELL_CYCLES)    : 1;
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES  > 0) ? TIMEOUT_CYCLES  - 1 : 0);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'((DWELL_CYCLES    > 0) ? DWELL_CYCLES    - 1 : 0);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic            DW_ON   = (DWELL_CYCLES != 0);

    logic [2:0]      state, state_n;
    logic            contact, contact_n;
    logic            pend, pend_n;
    logic [TO_W-1:0] to_cnt;
    logic [DW_W-1:0] dw_cnt;
    logic [DB_W-1:0] db_cnt;
    logic            btn_s1, btn_s2, db_level, db_prev;
    logic            press, to_hit, dw_hit;

    assign press  = db_level & ~db_prev;
    assign to_hit = (to_cnt == TO_LAST);
    assign dw_hit = DW_ON && (dw_cnt == DW_LAST);
    assign Estado = state;

    // Synchronize the raw button, then accept a new level only after
    // DEBOUNCE_CYCLES consecutive samples that differ from the current one.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            db_cnt   <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
        end else begin
            btn_s1  <= Boton;
            btn_s2  <= btn_s1;
            db_prev <= db_level;
            if (btn_s2 != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= btn_s2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Next-state, contact index and pending-press decisions.
    always_comb begin
        state_n   = state;
        contact_n = contact;
        pend_n    = pend;
        case (state)
            S_IDLE: begin
                contact_n = 1'b0;
                pend_n    = 1'b0;
                if (Start) state_n = S_LEER;
            end
            S_LEER: begin
                contact_n = 1'b0;
                pend_n    = 1'b0;
                if (Hecho)       state_n = S_L0;
                else if (to_hit) state_n = S_ERROR;
            end
            S_L0: begin
                if (press)   pend_n  = 1'b1;
                if (LCD_Ack) state_n = S_L1;
            end
            S_L1: begin
                if (press)   pend_n  = 1'b1;
                if (LCD_Ack) state_n = S_PAUSA;
            end
            S_PAUSA: begin
                // A re-read request wins; otherwise any advance cause (held
                // press, fresh press, dwell expiry) yields one single advance.
                if (Start) begin
                    state_n   = S_LEER;
                    contact_n = 1'b0;
                    pend_n    = 1'b0;
                end else if (pend || press || dw_hit) begin
                    state_n   = S_L0;
                    contact_n = ~contact;
                    pend_n    = 1'b0;
                end
            end
            S_ERROR: begin
                if (Start) begin
                    state_n   = S_LEER;
                    contact_n = 1'b0;
                    pend_n    = 1'b0;
                end
            end
            default: begin
                state_n   = S_IDLE;
                contact_n = 1'b0;
                pend_n    = 1'b0;
            end
        endcase
    end

    // State, contact, pending flag and the two per-state counters; each
    // counter restarts from zero whenever its state is (re)entered.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            contact <= 1'b0;
            pend    <= 1'b0;
            to_cnt  <= '0;
            dw_cnt  <= '0;
        end else begin
            state   <= state_n;
            contact <= contact_n;
            pend    <= pend_n;
            to_cnt  <= (state == S_LEER  && state_n == S_LEER)  ? to_cnt + 1'b1 : '0;
            dw_cnt  <= (state == S_PAUSA && state_n == S_PAUSA) ? dw_cnt + 1'b1 : '0;
        end
    end

    // Registered outputs decoded from the next state so they line up with Estado.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Habilitar <= 1'b0;
            LCD_Req   <= 1'b0;
            LCD_Linea <= 1'b0;
            DatoW     <= 2'b00;
            Error     <= 1'b0;
        end else begin
            Habilitar <= (state_n == S_LEER);
            LCD_Req   <= (state_n == S_L0) || (state_n == S_L1);
            LCD_Linea <= (state_n == S_L1);
            Error     <= (state_n == S_ERROR);
            case (state_n)
                S_L0:    DatoW <= {contact_n, 1'b0};
                S_L1:    DatoW <= {contact_n, 1'b1};
                default: DatoW <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_lcd_sequencer.sv
// Directed bench for sim_lcd_sequencer. An LCD writer model acknowledges each
// request and checks every written line against an expected-line queue.
module tb_sim_lcd_sequencer;

    localparam int TIMEOUT  = 100;
    localparam int DWELL    = 50;
    localparam int DEBOUNCE = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEER  = 3'd1;
    localparam logic [2:0] S_L0    = 3'd2;
    localparam logic [2:0] S_L1    = 3'd3;
    localparam logic [2:0] S_PAUSA = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic       clk, rst_n, start, boton, hecho, man_ack, rsp_ack, lcd_ack;
    logic       habilitar, lcd_req, lcd_linea, error;
    logic [1:0] dato_w;
    logic [2:0] estado;

    int         total = 0;
    int         bad = 0;
    logic [2:0] exp_q[$];     // {LCD_Linea, DatoW} of each expected LCD write
    int         ack_dly = 3;
    bit         ack_en = 0;
    int         l0_cnt = 0;

    assign lcd_ack = man_ack | rsp_ack;

    sim_lcd_sequencer #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .DWELL_CYCLES   (DWELL),
        .DEBOUNCE_CYCLES(DEBOUNCE)
    ) dut (
        .CLK      (clk),
        .Reset    (rst_n),
        .Start    (start),
        .Boton    (boton),
        .Habilitar(habilitar),
        .Hecho    (hecho),
        .DatoW    (dato_w),
        .LCD_Req  (lcd_req),
        .LCD_Linea(lcd_linea),
        .LCD_Ack  (lcd_ack),
        .Error    (error),
        .Estado   (estado)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (estado !== s && n < max_cyc) begin
            step();
            n++;
        end
        check(tag, 32'(estado), 32'(s));
    endtask

    task automatic push_contact(input logic c);
        exp_q.push_back({1'b0, c, 1'b0});
        exp_q.push_back({1'b1, c, 1'b1});
    endtask

    // Count entries into L0 (one per displayed contact).
    initial begin
        logic [2:0] prev;
        prev = S_IDLE;
        forever begin
            step();
            if (estado == S_L0 && prev != S_L0) l0_cnt++;
            prev = estado;
        end
    end

    // LCD writer model: ack each request ack_dly cycles after it is seen,
    // checking hold stability and the line against the expected queue.
    initial begin
        logic [2:0] line;
        rsp_ack = 1'b0;
        forever begin
            step();
            while (ack_en && lcd_req === 1'b1) begin
                line = {lcd_linea, dato_w};
                for (int i = 1; i < ack_dly; i++) begin
                    step();
                    check("req_hold", {28'd0, lcd_req, lcd_linea, dato_w}, {28'd0, 1'b1, line});
                end
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("lcd_line", 32'(line), 32'(exp_q.pop_front()));
                rsp_ack = 1'b1;
                step();
                rsp_ack = 1'b0;
            end
        end
    end

    initial begin
        int hab_cnt, n, l0_base;
        rst_n = 1'b0; start = 1'b0; boton = 1'b0; hecho = 1'b0; man_ack = 1'b0;
        repeat (3) step();
        check("rst_estado", 32'(estado), 32'(S_IDLE));
        check("rst_hab", 32'(habilitar), 32'd0);
        check("rst_req", 32'(lcd_req), 32'd0);
        check("rst_datow", 32'(dato_w), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        rst_n = 1'b1;
        ack_en = 1'b1;
        step();

        // Normal read: Hecho 20 cycles after Start, Ack 3 cycles after Req.
        push_contact(1'b0);
        start = 1'b1; step(); start = 1'b0;
        check("leer_estado", 32'(estado), 32'(S_LEER));
        check("leer_hab", 32'(habilitar), 32'd1);
        hab_cnt = 0;
        for (int i = 0; i < 19; i++) begin hab_cnt += int'(habilitar); step(); end
        hecho = 1'b1; hab_cnt += int'(habilitar); step(); hecho = 1'b0;
        check("hab_len", 32'(hab_cnt), 32'd20);
        check("hecho_hab", 32'(habilitar), 32'd0);
        check("hecho_estado", 32'(estado), 32'(S_L0));
        check("hecho_req", 32'(lcd_req), 32'd1);
        check("hecho_datow", 32'(dato_w), 32'd0);
        wait_state(S_L1, 10, "est_l1");
        wait_state(S_PAUSA, 10, "est_pausa");
        check("req_low_pausa", 32'(lcd_req), 32'd0);
        check("sb_drain1", 32'(exp_q.size()), 32'd0);

        // Auto-advance after DWELL cycles, then wrap back to contact 0.
        push_contact(1'b1);
        n = 0;
        while (estado == S_PAUSA && n < 60) begin step(); n++; end
        check("dwell_len1", 32'(n), 32'(DWELL));
        check("dwell_datow2", 32'(dato_w), 32'd2);
        wait_state(S_PAUSA, 20, "pausa2");
        push_contact(1'b0);
        n = 0;
        while (estado == S_PAUSA && n < 60) begin step(); n++; end
        check("dwell_len2", 32'(n), 32'(DWELL));
        check("dwell_wrap", 32'(dato_w), 32'd0);
        wait_state(S_PAUSA, 20, "pausa3");

        // Bouncing press in PAUSA: 3 high, 1 low, 10 high -> one advance.
        push_contact(1'b1);
        l0_base = l0_cnt;
        boton = 1'b1; repeat (3) step();
        boton = 1'b0; step();
        boton = 1'b1; repeat (10) step();
        boton = 1'b0;
        repeat (30) step();
        check("bounce_one_adv", 32'(l0_cnt - l0_base), 32'd1);
        check("bounce_pausa", 32'(estado), 32'(S_PAUSA));

        // Press held from L0, second press in L1 dropped; slow writer.
        ack_dly = 16;
        push_contact(1'b0);
        push_contact(1'b1);
        l0_base = l0_cnt;
        wait_state(S_L0, 60, "dwell_l0");
        check("pend_c0", 32'(dato_w), 32'd0);
        boton = 1'b1; repeat (8) step();
        boton = 1'b0; repeat (8) step();
        boton = 1'b1; repeat (8) step();
        boton = 1'b0;
        wait_state(S_PAUSA, 20, "pend_pausa");
        wait_state(S_L0, 2, "pend_fast");
        check("pend_c1", 32'(dato_w), 32'd2);
        wait_state(S_PAUSA, 40, "pend_back");
        check("pend_adv", 32'(l0_cnt - l0_base), 32'd2);

        // Press event landing on the dwell-expiry edge: a single advance.
        ack_dly = 3;
        push_contact(1'b0);
        l0_base = l0_cnt;
        repeat (DWELL - DEBOUNCE - 3) step();
        boton = 1'b1; repeat (10) step();
        boton = 1'b0;
        repeat (30) step();
        check("coinc_one_adv", 32'(l0_cnt - l0_base), 32'd1);
        check("coinc_pausa", 32'(estado), 32'(S_PAUSA));

        // Start in L0 is ignored; Start in PAUSA re-reads with contact 0.
        push_contact(1'b1);
        wait_state(S_L0, 40, "pre_start_l0");
        start = 1'b1; step(); start = 1'b0;
        check("start_l0_est", 32'(estado), 32'(S_L0));
        check("start_l0_hab", 32'(habilitar), 32'd0);
        wait_state(S_PAUSA, 10, "pre_start_pausa");
        start = 1'b1; step(); start = 1'b0;
        check("start_pausa_est", 32'(estado), 32'(S_LEER));
        check("start_pausa_hab", 32'(habilitar), 32'd1);
        push_contact(1'b0);
        repeat (5) step();
        hecho = 1'b1; step(); hecho = 1'b0;
        check("restart_datow", 32'(dato_w), 32'd0);
        wait_state(S_PAUSA, 10, "restart_pausa");

        // Timeout: Hecho never rises.
        start = 1'b1; step(); start = 1'b0;
        check("to_leer", 32'(estado), 32'(S_LEER));
        repeat (TIMEOUT - 1) step();
        check("to_before_est", 32'(estado), 32'(S_LEER));
        check("to_before_err", 32'(error), 32'd0);
        step();
        check("to_err", 32'(error), 32'd1);
        check("to_est", 32'(estado), 32'(S_ERROR));
        check("to_hab", 32'(habilitar), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        check("err_restart_est", 32'(estado), 32'(S_LEER));
        check("err_restart_err", 32'(error), 32'd0);
        check("err_restart_hab", 32'(habilitar), 32'd1);
        push_contact(1'b0);
        hecho = 1'b1; step(); hecho = 1'b0;
        wait_state(S_PAUSA, 20, "err_done_pausa");

        // Reset asserted mid-handshake in L1, then a late Ack.
        ack_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        hecho = 1'b1; step(); hecho = 1'b0;
        check("man_l0", 32'(estado), 32'(S_L0));
        man_ack = 1'b1; step(); man_ack = 1'b0;
        check("man_l1", 32'(estado), 32'(S_L1));
        check("man_l1_req", 32'(lcd_req), 32'd1);
        check("man_l1_line", {30'd0, lcd_linea, dato_w[0]}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_est", 32'(estado), 32'(S_IDLE));
        check("async_req", 32'(lcd_req), 32'd0);
        check("async_hab", 32'(habilitar), 32'd0);
        check("async_datow", 32'(dato_w), 32'd0);
        check("async_linea", 32'(lcd_linea), 32'd0);
        step();
        rst_n = 1'b1;
        man_ack = 1'b1; step(); man_ack = 1'b0;
        check("late_ack_est", 32'(estado), 32'(S_IDLE));
        check("late_ack_req", 32'(lcd_req), 32'd0);
        repeat (3) step();
        check("late_ack_idle", 32'(estado), 32'(S_IDLE));
        check("sb_drain_end", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
